// File: rtl/facto_pkg.sv
// facto_pkg: shared types and constants for the factorial host sequencer.
//   facto_host_state_e : sequencer FSM state encoding
//   OPDONE_*_BIT       : bit positions inside the unit's 2-bit status word
//   FACTO_MAX_OPERAND  : largest operand whose factorial fits in 128 bits
//   operand_in_range() : range test applied to an incoming request
package facto_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4,
      CLEAR = 3'd5
   } facto_host_state_e;

   localparam int OPDONE_DONE_BIT   = 1;
   localparam int OPDONE_BUSY_BIT   = 0;
   localparam int FACTO_MAX_OPERAND = 34;

   // True when the factorial of op fits in the 128-bit result.
   function automatic logic operand_in_range(input logic [63:0] op,
                                             input logic [63:0] max_op);
      return (op <= max_op);
   endfunction

endpackage

// File: rtl/facto_wdt.sv
// facto_wdt: clearable, enabled up-counter used as the done-poll watchdog.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear of the count (wins over en)
//   en           : count one step per cycle
//   expire       : high for the cycle in which an enabled count sits at TIMEOUT-1
module facto_wdt #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_r;

   // Watchdog count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Expiry is combinational so the FSM can leave WAIT in the same cycle.
   assign expire = en && (count_r == LAST_COUNT);

endmodule

// File: rtl/facto_host.sv
// facto_host: host-side command sequencer for the factorial accelerator.
//   req_valid/req_ready/req_operand : factorial request port
//   rsp_valid/rsp_ready/rsp_result_h/rsp_result_l/rsp_error : response port
//   f_opstart/f_opclear/f_operand   : control outputs to the factorial unit
//   f_opdone/f_result_h/f_result_l  : status and result from the factorial unit
// One request is held in flight. All outputs are registered.
module facto_host
   import facto_pkg::*;
#(
   parameter int MAX_OPERAND = FACTO_MAX_OPERAND,
   parameter int TIMEOUT     = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_operand,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result_h,
   output logic [63:0] rsp_result_l,
   output logic        rsp_error,
   output logic        f_opstart,
   output logic        f_opclear,
   output logic [63:0] f_operand,
   input  logic [1:0]  f_opdone,
   input  logic [63:0] f_result_h,
   input  logic [63:0] f_result_l
);

   facto_host_state_e state_r;
   logic              reject_r;     // current response is a range-reject
   logic              wdt_clr_s;
   logic              wdt_en_s;
   logic              wdt_expire_s;
   logic              busy_unused_s;

   // The busy bit carries no information the sequencer acts on.
   assign busy_unused_s = f_opdone[OPDONE_BUSY_BIT];

   assign wdt_clr_s = (state_r == START);
   assign wdt_en_s  = (state_r == WAIT);

   facto_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wdt_clr_s),
      .en      (wdt_en_s),
      .expire  (wdt_expire_s)
   );

   // Sequencer FSM; every output is set on the transition into its state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         reject_r     <= 1'b0;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_error    <= 1'b0;
         rsp_result_h <= 64'd0;
         rsp_result_l <= 64'd0;
         f_opstart    <= 1'b0;
         f_opclear    <= 1'b0;
         f_operand    <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (operand_in_range(req_operand, 64'(MAX_OPERAND))) begin
                     f_operand <= req_operand;
                     f_opclear <= 1'b1;
                     reject_r  <= 1'b0;
                     state_r   <= LOAD;
                  end else begin
                     // Out of range: answer at once, never touch the unit.
                     rsp_valid    <= 1'b1;
                     rsp_error    <= 1'b1;
                     rsp_result_h <= 64'd0;
                     rsp_result_l <= 64'd0;
                     reject_r     <= 1'b1;
                     state_r      <= RESP;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            LOAD: begin
               f_opclear <= 1'b0;
               f_opstart <= 1'b1;
               state_r   <= START;
            end
            START: begin
               state_r <= WAIT;
            end
            WAIT: begin
               // Done wins over a coincident watchdog expiry.
               if (f_opdone[OPDONE_DONE_BIT]) begin
                  rsp_result_h <= f_result_h;
                  rsp_result_l <= f_result_l;
                  rsp_error    <= 1'b0;
                  rsp_valid    <= 1'b1;
                  f_opstart    <= 1'b0;
                  state_r      <= RESP;
               end else if (wdt_expire_s) begin
                  rsp_result_h <= 64'd0;
                  rsp_result_l <= 64'd0;
                  rsp_error    <= 1'b1;
                  rsp_valid    <= 1'b1;
                  f_opstart    <= 1'b0;
                  state_r      <= RESP;
               end else begin
                  state_r <= WAIT;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (reject_r) begin
                     req_ready <= 1'b1;
                     state_r   <= IDLE;
                  end else begin
                     f_opclear <= 1'b1;
                     state_r   <= CLEAR;
                  end
               end else begin
                  state_r <= RESP;
               end
            end
            CLEAR: begin
               f_opclear <= 1'b0;
               req_ready <= 1'b1;
               state_r   <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
               f_opstart <= 1'b0;
               f_opclear <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_facto_host.sv
// tb_facto_host: self-checking bench for facto_host with a behavioural
// factorial unit model, a vector table, a response scoreboard and a few
// hand-written corner sequences (mid-operation reset).
module tb_facto_host;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_operand = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result_h;
   logic [63:0] rsp_result_l;
   logic        rsp_error;
   logic        f_opstart;
   logic        f_opclear;
   logic [63:0] f_operand;
   logic [1:0]  f_opdone;
   logic [63:0] f_result_h;
   logic [63:0] f_result_l;

   facto_host #(.MAX_OPERAND(34), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_operand  (req_operand),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result_h (rsp_result_h),
      .rsp_result_l (rsp_result_l),
      .rsp_error    (rsp_error),
      .f_opstart    (f_opstart),
      .f_opclear    (f_opclear),
      .f_operand    (f_operand),
      .f_opdone     (f_opdone),
      .f_result_h   (f_result_h),
      .f_result_l   (f_result_l)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] fact(input int n);
      logic [127:0] r;
      r = 128'd1;
      for (int i = 2; i <= n; i++) r = r * 128'(i);
      return r;
   endfunction

   // Factorial unit model: done comes unit_lat cycles after opstart is seen
   // (unit_lat = 0 means never).
   int           unit_lat = 0;
   logic         unit_done_r;
   int           unit_cnt_r;
   logic [127:0] unit_res_r;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         unit_done_r <= 1'b0;
         unit_cnt_r  <= 0;
         unit_res_r  <= 128'd0;
      end else if (f_opclear) begin
         unit_done_r <= 1'b0;
         unit_cnt_r  <= 0;
         unit_res_r  <= 128'd0;
      end else if (f_opstart && !unit_done_r) begin
         unit_cnt_r <= unit_cnt_r + 1;
         if (unit_lat != 0 && unit_cnt_r + 1 == unit_lat) begin
            unit_done_r <= 1'b1;
            unit_res_r  <= fact(int'(f_operand[5:0]));
         end
      end
   end

   assign f_opdone   = {unit_done_r, f_opstart & ~unit_done_r};
   assign f_result_h = unit_res_r[127:64];
   assign f_result_l = unit_res_r[63:0];

   // Cycle counter and protocol monitor.
   int           cyc = 0;
   int           clr_rise = 0;
   int           st_rise = 0;
   int           ovl_cnt = 0;
   int           rdy_cnt = 0;
   int           stab_cnt = 0;
   logic         clr_prev = 1'b0;
   logic         st_prev = 1'b0;
   logic         hold_prev = 1'b0;
   logic [128:0] held_r = 129'd0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset_n) begin
         if (f_opstart && f_opclear) ovl_cnt <= ovl_cnt + 1;
         if (rsp_valid && req_ready) rdy_cnt <= rdy_cnt + 1;
         if (f_opclear && !clr_prev) clr_rise <= clr_rise + 1;
         if (f_opstart && !st_prev) st_rise <= st_rise + 1;
         if (hold_prev && !(rsp_valid && {rsp_error, rsp_result_h, rsp_result_l} == held_r))
            stab_cnt <= stab_cnt + 1;
         clr_prev  <= f_opclear;
         st_prev   <= f_opstart;
         hold_prev <= rsp_valid && !rsp_ready;
         held_r    <= {rsp_error, rsp_result_h, rsp_result_l};
      end else begin
         clr_prev  <= 1'b0;
         st_prev   <= 1'b0;
         hold_prev <= 1'b0;
      end
   end

   int n_vec = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [63:0] operand;
      int          lat;
      int          hold;
   } vec_t;

   typedef struct {
      logic        err;
      logic [63:0] h;
      logic [63:0] l;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[10];

   task automatic wait_ready();
      int waited;
      waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("req_ready_wait", req_ready, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t         e;
      exp_t         got;
      logic [127:0] r;
      logic         in_range;
      int           lat_exp;
      int           hs;
      int           waited;
      int           clr0;
      int           st0;
      in_range = (v.operand <= 64'd34);
      unit_lat = v.lat;
      if (!in_range) begin
         e = '{1'b1, 64'd0, 64'd0};
         lat_exp = 1;
      end else if (v.lat == 0 || v.lat > TO) begin
         e = '{1'b1, 64'd0, 64'd0};
         lat_exp = 3 + TO;
      end else begin
         r = fact(int'(v.operand));
         e = '{1'b0, r[127:64], r[63:0]};
         lat_exp = 3 + v.lat;
      end
      wait_ready();
      clr0 = clr_rise;
      st0  = st_rise;
      req_valid   = 1'b1;
      req_operand = v.operand;
      hs = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      check("ready_drop", req_ready, 1'b0);
      if (in_range) begin
         check("load_clear", {f_opclear, f_opstart}, 2'b10);
         check("load_operand", f_operand, v.operand);
         @(negedge clk);
         check("start_level", {f_opstart, f_opclear}, 2'b10);
      end
      waited = 0;
      while (!rsp_valid && waited < TO + 50) begin
         @(negedge clk);
         waited++;
      end
      check("rsp_latency", cyc - hs, lat_exp);
      if (v.hold > 0) begin
         repeat (v.hold) @(negedge clk);
         check("rsp_held", {rsp_valid, req_ready}, 2'b10);
      end
      got = sb_q.pop_front();
      check("rsp_error", rsp_error, got.err);
      check("rsp_h", rsp_result_h, got.h);
      check("rsp_l", rsp_result_l, got.l);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_dropped", rsp_valid, 1'b0);
      if (in_range) begin
         check("clear_pulse", {f_opclear, req_ready, f_opstart}, 3'b100);
         @(negedge clk);
         check("idle_ready", {req_ready, f_opclear}, 2'b10);
         check("opclear_edges", clr_rise - clr0, 2);
         check("opstart_edges", st_rise - st0, 1);
      end else begin
         check("reject_idle", req_ready, 1'b1);
         check("reject_no_unit", (clr_rise - clr0) + (st_rise - st0), 0);
      end
   endtask

   initial begin
      vecs[0] = '{64'd5, 10, 0};
      vecs[1] = '{64'd0, 3, 0};
      vecs[2] = '{64'd1, 1, 0};
      vecs[3] = '{64'd34, 7, 0};
      vecs[4] = '{64'd35, 5, 0};
      vecs[5] = '{64'd5, 0, 0};
      vecs[6] = '{64'd12, TO, 0};
      vecs[7] = '{64'd20, 4, 10};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 3};
      vecs[9] = '{64'd3, TO + 1, 0};

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_ctrl", {req_ready, rsp_valid, rsp_error, f_opstart, f_opclear}, 5'b00000);
      check("reset_results", {rsp_result_h, rsp_result_l}, 128'd0);
      check("reset_operand", f_operand, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1'b1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset dropped while polling in WAIT.
      unit_lat = 0;
      wait_ready();
      req_valid   = 1'b1;
      req_operand = 64'd9;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("wait_opstart", f_opstart, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_ctrl", {req_ready, rsp_valid, rsp_error, f_opstart, f_opclear}, 5'b00000);
      check("async_reset_results", {rsp_result_h, rsp_result_l}, 128'd0);
      check("async_reset_operand", f_operand, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_one_cycle_after_release", req_ready, 1'b1);
      @(negedge clk);
      run_vec('{64'd7, 5, 2});

      check("no_start_clear_overlap", ovl_cnt, 0);
      check("no_rsp_valid_with_ready", rdy_cnt, 0);
      check("rsp_stable_while_stalled", stab_cnt, 0);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
